// File: rtl/q610_pkg.sv
// Shared Q6.10 fixed-point definitions for the divider and reciprocal units.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package q610_pkg;

  localparam int          Q_WIDTH   = 16;
  localparam int          Q_FRAC    = 10;
  localparam logic [15:0] Q_SAT_MAX = 16'h7FFF;
  // Negative saturation is the mirror of Q_SAT_MAX, keeping the range symmetric.
  localparam logic [15:0] Q_SAT_MIN = 16'h8001;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } div_state_t;

endpackage

// File: rtl/q610_abs.sv
// Signed two's-complement value to unsigned magnitude (combinational).
// Latency: 0 cycles. Backpressure: none.
// Ports: i_val signed input, o_mag unsigned magnitude (most negative value maps to 2^(W-1)).
module q610_abs #(
  parameter int W = 16
) (
  input  logic [W-1:0] i_val,
  output logic [W-1:0] o_mag
);

  // Read as unsigned, -(-2^(W-1)) = 2^(W-1) is exact, so no overflow case exists.
  assign o_mag = i_val[W-1] ? (~i_val + W'(1)) : i_val;

endmodule

// File: rtl/q610_divider.sv
// Sequential signed Q6.10 divider (restoring, one quotient bit per clock) with saturation.
// Latency: fixed 27 clocks from accepted start to o_done, divide-by-zero included.
// Backpressure: none; i_start is only honoured in IDLE, o_busy flags an operation in flight.
// Ports: clk/reset (async, active-high); i_start/i_num/i_den/i_abs sampled at start;
//        o_busy, o_done (1-cycle pulse), o_data/o_sat/o_divzero held until the next o_done.
module q610_divider
  import q610_pkg::*;
#(
  parameter int WIDTH = Q_WIDTH,
  parameter int FRAC  = Q_FRAC
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_num,
  input  logic [WIDTH-1:0] i_den,
  input  logic             i_abs,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_data,
  output logic             o_sat,
  output logic             o_divzero
);

  localparam int DW = WIDTH + FRAC;   // dividend/quotient width, also the iteration count
  localparam int CW = $clog2(DW);

  logic [WIDTH-1:0] num_mag, den_mag;

  q610_abs #(.W(WIDTH)) u_abs_num (.i_val(i_num), .o_mag(num_mag));
  q610_abs #(.W(WIDTH)) u_abs_den (.i_val(i_den), .o_mag(den_mag));

  div_state_t       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [DW-1:0]    dvd_q, dvd_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [DW-1:0]    quo_q, quo_d;
  logic [WIDTH-1:0] den_q, den_d;
  logic             neg_q, neg_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             sat_q, sat_d;
  logic             divz_q, divz_d;
  logic             done_q, done_d;

  // The remainder is always below |den| <= 2^(WIDTH-1), so after the shift it
  // still fits WIDTH+1 bits; one extra bit on the difference carries the sign.
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] diff;
  logic             ovf;

  assign rem_sh = {rem_q[WIDTH-1:0], dvd_q[DW-1]};
  assign diff   = {1'b0, rem_sh} - {2'b00, den_q};
  // Any quotient bit at or above the sign position exceeds Q_SAT_MAX.
  assign ovf    = |quo_q[DW-1:WIDTH-1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    den_d   = den_q;
    neg_d   = neg_q;
    dz_d    = dz_q;
    data_d  = data_q;
    sat_d   = sat_q;
    divz_d  = divz_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_start) begin
          den_d   = den_mag;
          neg_d   = (i_num[WIDTH-1] ^ i_den[WIDTH-1]) & ~i_abs;
          dz_d    = (i_den == '0);
          dvd_d   = {num_mag, {FRAC{1'b0}}};
          rem_d   = '0;
          quo_d   = '0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end

      CALC: begin
        dvd_d = {dvd_q[DW-2:0], 1'b0};
        if (!diff[WIDTH+1]) begin
          rem_d = diff[WIDTH:0];
          quo_d = {quo_q[DW-2:0], 1'b1};
        end else begin
          rem_d = rem_sh;
          quo_d = {quo_q[DW-2:0], 1'b0};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(DW - 1)) begin
          state_d = DONE;
        end
      end

      DONE: begin
        done_d = 1'b1;
        divz_d = dz_q;
        sat_d  = dz_q | ovf;
        // A zero divisor ran the full loop on garbage; its quotient is ignored.
        if (dz_q || ovf) begin
          data_d = neg_q ? WIDTH'(Q_SAT_MIN) : WIDTH'(Q_SAT_MAX);
        end else begin
          data_d = neg_q ? -quo_q[WIDTH-1:0] : quo_q[WIDTH-1:0];
        end
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      den_q   <= '0;
      neg_q   <= 1'b0;
      dz_q    <= 1'b0;
      data_q  <= '0;
      sat_q   <= 1'b0;
      divz_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      den_q   <= den_d;
      neg_q   <= neg_d;
      dz_q    <= dz_d;
      data_q  <= data_d;
      sat_q   <= sat_d;
      divz_q  <= divz_d;
      done_q  <= done_d;
    end
  end

  assign o_busy    = (state_q != IDLE);
  assign o_done    = done_q;
  assign o_data    = data_q;
  assign o_sat     = sat_q;
  assign o_divzero = divz_q;

endmodule

// File: tb/tb_q610_divider.sv
// Self-checking bench for q610_divider: vector table + model-based random cases,
// scoreboard queue of expected results, and handshake/reset corner sequences.
// Inputs driven and outputs sampled on the falling edge.
module tb_q610_divider;

  typedef struct {
    logic [15:0] num;
    logic [15:0] den;
    logic        abs_en;
    logic [15:0] data;
    logic        sat;
    logic        dz;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_start;
  logic [15:0] i_num;
  logic [15:0] i_den;
  logic        i_abs;
  logic        o_busy;
  logic        o_done;
  logic [15:0] o_data;
  logic        o_sat;
  logic        o_divzero;

  q610_divider dut (
    .clk       (clk),
    .reset     (reset),
    .i_start   (i_start),
    .i_num     (i_num),
    .i_den     (i_den),
    .i_abs     (i_abs),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_data    (o_data),
    .o_sat     (o_sat),
    .o_divzero (o_divzero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   checks = 0;
  int   errors = 0;
  int   start_cyc = 0;
  vec_t exp_q[$];
  vec_t last_exp;
  vec_t tab[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [15:0] n, input logic [15:0] d, input logic a,
                              input logic [15:0] r, input logic s, input logic z);
    vec_t v;
    v.num = n; v.den = d; v.abs_en = a; v.data = r; v.sat = s; v.dz = z;
    return v;
  endfunction

  // Reference: exact integer division of magnitudes, truncated, then saturate and sign.
  function automatic vec_t model(input logic [15:0] n, input logic [15:0] d, input logic a);
    longint an, ad, q, mag;
    logic   neg, sat;
    an  = n[15] ? (65536 - longint'(n)) : longint'(n);
    ad  = d[15] ? (65536 - longint'(d)) : longint'(d);
    neg = (n[15] ^ d[15]) & ~a;
    if (ad == 0) begin
      mag = 32767; sat = 1'b1;
    end else begin
      q   = (an * 1024) / ad;
      sat = (q > 32767);
      mag = sat ? 32767 : q;
    end
    return mk(n, d, a, neg ? 16'(65536 - mag) : 16'(mag), sat, (ad == 0));
  endfunction

  // Called on a falling edge; the next rising edge accepts the start.
  task automatic drive_start(input vec_t v);
    i_num = v.num; i_den = v.den; i_abs = v.abs_en; i_start = 1'b1;
    exp_q.push_back(v);
    @(negedge clk);
    start_cyc = cyc;
    i_start = 1'b0;
    i_num = 16'($urandom); i_den = 16'($urandom); i_abs = 1'($urandom);
  endtask

  task automatic wait_done(input string tag);
    vec_t e;
    while (!o_done && (cyc - start_cyc) < 60) @(negedge clk);
    chk({tag, " latency"}, 32'(cyc - start_cyc), 32'd27);
    if (o_done && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      last_exp = e;
      chk({tag, " data"},    32'(o_data),    32'(e.data));
      chk({tag, " sat"},     32'(o_sat),     32'(e.sat));
      chk({tag, " divzero"}, 32'(o_divzero), 32'(e.dz));
      chk({tag, " busy"},    32'(o_busy),    32'd0);
    end
  endtask

  task automatic expect_no_done(input string tag, input int ncyc);
    int seen = 0;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      if (o_done) seen++;
    end
    chk({tag, " spurious done"}, 32'(seen), 32'd0);
  endtask

  initial begin
    tab[0]  = mk(16'h0C00, 16'h0800, 1'b0, 16'h0600, 1'b0, 1'b0); // 3/2
    tab[1]  = mk(16'hFC00, 16'h1000, 1'b0, 16'hFF00, 1'b0, 1'b0); // -1/4
    tab[2]  = mk(16'hFC00, 16'h1000, 1'b1, 16'h0100, 1'b0, 1'b0); // |-1/4|
    tab[3]  = mk(16'h0400, 16'h0C00, 1'b0, 16'h0155, 1'b0, 1'b0); // 1/3 truncated
    tab[4]  = mk(16'h0400, 16'h0000, 1'b0, 16'h7FFF, 1'b1, 1'b1); // 1/0
    tab[5]  = mk(16'hFC00, 16'h0000, 1'b0, 16'h8001, 1'b1, 1'b1); // -1/0
    tab[6]  = mk(16'h4000, 16'h0100, 1'b0, 16'h7FFF, 1'b1, 1'b0); // 16/0.25 overflow
    tab[7]  = mk(16'h8000, 16'h0400, 1'b0, 16'h8001, 1'b1, 1'b0); // -32/1
    tab[8]  = mk(16'h0000, 16'hF000, 1'b0, 16'h0000, 1'b0, 1'b0); // 0/-4
    tab[9]  = mk(16'h8000, 16'h8000, 1'b0, 16'h0400, 1'b0, 1'b0); // -32/-32
    tab[10] = mk(16'hFC00, 16'h0C00, 1'b0, 16'hFEAB, 1'b0, 1'b0); // -1/3 toward zero
    tab[11] = mk(16'h0001, 16'h7FFF, 1'b0, 16'h0000, 1'b0, 1'b0); // underflow to 0

    reset = 1'b1; i_start = 1'b0; i_num = '0; i_den = '0; i_abs = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset busy",    32'(o_busy),    32'd0);
    chk("reset done",    32'(o_done),    32'd0);
    chk("reset data",    32'(o_data),    32'd0);
    chk("reset sat",     32'(o_sat),     32'd0);
    chk("reset divzero", 32'(o_divzero), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      drive_start(tab[i]);
      chk($sformatf("vec%0d busy after start", i), 32'(o_busy), 32'd1);
      wait_done($sformatf("vec%0d", i));
      @(negedge clk);
      chk($sformatf("vec%0d done pulse width", i), 32'(o_done), 32'd0);
      chk($sformatf("vec%0d data held", i), 32'(o_data), 32'(last_exp.data));
    end

    for (int i = 0; i < 6; i++) begin
      drive_start(model(16'($urandom), 16'($urandom), 1'($urandom)));
      wait_done($sformatf("rnd%0d", i));
      @(negedge clk);
    end

    // Start pulse while busy must be ignored.
    drive_start(tab[0]);
    repeat (10) @(negedge clk);
    i_start = 1'b1; i_num = 16'h0400; i_den = 16'h0000; i_abs = 1'b0;
    @(negedge clk);
    i_start = 1'b0;
    wait_done("ignore");
    expect_no_done("ignore", 35);

    // Start in the done cycle is accepted: back-to-back operations.
    drive_start(tab[3]);
    wait_done("b2b first");
    drive_start(tab[5]);
    wait_done("b2b second");
    @(negedge clk);

    // Async reset mid-calculation; flags and data are non-zero beforehand.
    drive_start(tab[1]);
    repeat (8) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midreset busy",    32'(o_busy),    32'd0);
    chk("midreset done",    32'(o_done),    32'd0);
    chk("midreset data",    32'(o_data),    32'd0);
    chk("midreset sat",     32'(o_sat),     32'd0);
    chk("midreset divzero", 32'(o_divzero), 32'd0);
    void'(exp_q.pop_back());
    @(negedge clk);
    reset = 1'b0;
    expect_no_done("after reset", 35);
    drive_start(tab[10]);
    wait_done("post reset");
    @(negedge clk);

    chk("scoreboard empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
